// File: rtl/fast_pkg.sv
// Shared ring geometry for the FAST segment-test stage.
package fast_pkg;
  localparam int RING_SIZE = 16;
  localparam int IDX_W     = $clog2(RING_SIZE);

  typedef logic [RING_SIZE-1:0] ring_mask_t;
  typedef logic [IDX_W-1:0]     ring_idx_t;

  // Position k steps after start s on the circular ring.
  function automatic ring_idx_t ring_idx(input int s, input int k);
    int t;
    t = (s + k) % RING_SIZE;
    return t[IDX_W-1:0];
  endfunction
endpackage

// File: rtl/fast_arc_detect.sv
// Per-start arc terms: bit s is set when N ring pixels starting at s are all set in the mask.
module fast_arc_detect
  import fast_pkg::*;
#(
  parameter int N = 9
) (
  input  ring_mask_t mask_i,
  output ring_mask_t start_hit_o
);

  if (N < 1 || N > RING_SIZE) begin : g_bad_n
    $error("fast_arc_detect: N must be in 1..16");
  end

  always_comb begin
    start_hit_o = '1;
    for (int s = 0; s < RING_SIZE; s++) begin
      for (int k = 0; k < N; k++) begin
        start_hit_o[s] = start_hit_o[s] & mask_i[ring_idx(s, k)];
      end
    end
  end

endmodule

// File: rtl/fast_segment_test.sv
// FAST-N segment-test decision stage, two register stages, one candidate per cycle.
// Optional FAST_SEG_POLARITY_EN adds registered is_bright/is_dark outputs.
module fast_segment_test
  import fast_pkg::*;
#(
  parameter int N = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  ring_mask_t bright_mask,
  input  ring_mask_t dark_mask,
  output logic       out_valid,
  output logic       is_corner
`ifdef FAST_SEG_POLARITY_EN
  ,
  output logic       is_bright,
  output logic       is_dark
`endif
);

  // Valid-only stream: in_valid qualifies the masks in that cycle and is always
  // accepted; out_valid pulses once per accepted input, two cycles later, in order.

  ring_mask_t bright_and_d, dark_and_d;
  ring_mask_t bright_and_q, dark_and_q;
  logic       s1_valid_q;
  logic       out_valid_q, is_corner_q, is_corner_d;
  logic       bright_hit, dark_hit;

  fast_arc_detect #(.N(N)) u_bright (
    .mask_i      (bright_mask),
    .start_hit_o (bright_and_d)
  );

  fast_arc_detect #(.N(N)) u_dark (
    .mask_i      (dark_mask),
    .start_hit_o (dark_and_d)
  );

  // Data registers need no reset; only the valid bits gate the output.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      bright_and_q <= bright_and_d;
      dark_and_q   <= dark_and_d;
    end
  end

  assign bright_hit  = |bright_and_q;
  assign dark_hit    = |dark_and_q;
  assign is_corner_d = s1_valid_q ? (bright_hit | dark_hit) : is_corner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      is_corner_q <= 1'b0;
    end else begin
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      is_corner_q <= is_corner_d;
    end
  end

  assign out_valid = out_valid_q;
  assign is_corner = is_corner_q;

`ifdef FAST_SEG_POLARITY_EN
  logic is_bright_q, is_dark_q, is_bright_d, is_dark_d;

  assign is_bright_d = s1_valid_q ? bright_hit : is_bright_q;
  assign is_dark_d   = s1_valid_q ? dark_hit   : is_dark_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_bright_q <= 1'b0;
      is_dark_q   <= 1'b0;
    end else begin
      is_bright_q <= is_bright_d;
      is_dark_q   <= is_dark_d;
    end
  end

  assign is_bright = is_bright_q;
  assign is_dark   = is_dark_q;
`endif

endmodule

// File: tb/tb_fast_segment_test.sv
// Bench for fast_segment_test: three instances (N=9, N=1, N=16) share one input stream
// and are checked every cycle against a run-length reference model.
module tb_fast_segment_test;
  localparam int W = 5;  // {bright9, dark9, corner16, corner1, corner9}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] bright_mask, dark_mask;
  logic        ov9, ic9, ov1, ic1, ov16, ic16;
`ifdef FAST_SEG_POLARITY_EN
  logic        ib9, id9, ib1, id1, ib16, id16;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          run_cmp = 1'b0;
  logic [W-1:0] exp_q[$];
  int          cyc_q[$];
  logic [W-1:0] last_exp = '0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  fast_segment_test #(.N(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .bright_mask(bright_mask), .dark_mask(dark_mask),
    .out_valid(ov9), .is_corner(ic9)
`ifdef FAST_SEG_POLARITY_EN
    , .is_bright(ib9), .is_dark(id9)
`endif
  );

  fast_segment_test #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .bright_mask(bright_mask), .dark_mask(dark_mask),
    .out_valid(ov1), .is_corner(ic1)
`ifdef FAST_SEG_POLARITY_EN
    , .is_bright(ib1), .is_dark(id1)
`endif
  );

  fast_segment_test #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .bright_mask(bright_mask), .dark_mask(dark_mask),
    .out_valid(ov16), .is_corner(ic16)
`ifdef FAST_SEG_POLARITY_EN
    , .is_bright(ib16), .is_dark(id16)
`endif
  );

  // ---------------- reference model ----------------
  // Longest circular run of ones, found by scanning the mask written twice.
  function automatic logic arc_hit(input logic [15:0] m, input int n);
    logic [31:0] dbl;
    int run, best;
    dbl = {m, m};
    run = 0;
    best = 0;
    for (int i = 0; i < 32; i++) begin
      if (dbl[i]) run++;
      else run = 0;
      if (run > best) best = run;
    end
    return best >= n;
  endfunction

  function automatic logic [W-1:0] model(input logic [15:0] b, input logic [15:0] d);
    return {arc_hit(b, 9), arc_hit(d, 9),
            arc_hit(b, 16) | arc_hit(d, 16),
            arc_hit(b, 1)  | arc_hit(d, 1),
            arc_hit(b, 9)  | arc_hit(d, 9)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      last_exp = '0;
    end else if (in_valid) begin
      exp_q.push_back(model(bright_mask, dark_mask));
      cyc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    logic due;
    if (run_cmp) begin
      due = (cyc_q.size() > 0) && (cyc_q[0] == cyc - 1);
      if (due) begin
        last_exp = exp_q.pop_front();
        void'(cyc_q.pop_front());
      end
      check("out_valid_n9",  {31'd0, ov9},  {31'd0, due});
      check("out_valid_n1",  {31'd0, ov1},  {31'd0, due});
      check("out_valid_n16", {31'd0, ov16}, {31'd0, due});
      check("is_corner_n9",  {31'd0, ic9},  {31'd0, last_exp[0]});
      check("is_corner_n1",  {31'd0, ic1},  {31'd0, last_exp[1]});
      check("is_corner_n16", {31'd0, ic16}, {31'd0, last_exp[2]});
`ifdef FAST_SEG_POLARITY_EN
      check("is_dark_n9",    {31'd0, id9},  {31'd0, last_exp[3]});
      check("is_bright_n9",  {31'd0, ib9},  {31'd0, last_exp[4]});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic v, input logic [15:0] b, input logic [15:0] d);
    @(negedge clk);
    rst = r;
    in_valid = v;
    bright_mask = b;
    dark_mask = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, $urandom);
  endtask

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    int len, st;
    m = '0;
    case ($urandom_range(0, 3))
      0: m = 16'($urandom);
      1, 2: begin
        len = $urandom_range(1, 16);
        st  = $urandom_range(0, 15);
        for (int k = 0; k < len; k++) m[(st + k) % 16] = 1'b1;
        if ($urandom_range(0, 1) == 1) m = m | (16'($urandom) & 16'($urandom));
      end
      default: m = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
    endcase
    return m;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    bright_mask = '0;
    dark_mask = '0;

    // Hand-computed pins on the model itself.
    check("model_run9",       {31'd0, arc_hit(16'hFF80, 9)},  32'd1);
    check("model_alt",        {31'd0, arc_hit(16'hAAAA, 9)},  32'd0);
    check("model_wrap9",      {31'd0, arc_hit(16'hF01F, 9)},  32'd1);
    check("model_wrap8",      {31'd0, arc_hit(16'hF01E, 9)},  32'd0);
    check("model_full_n16",   {31'd0, arc_hit(16'hFFFF, 16)}, 32'd1);
    check("model_15_n16",     {31'd0, arc_hit(16'hFFFE, 16)}, 32'd0);
    check("model_one_n1",     {31'd0, arc_hit(16'h0010, 1)},  32'd1);
    check("model_zero_n1",    {31'd0, arc_hit(16'h0000, 1)},  32'd0);

    repeat (3) @(negedge clk);
    check("reset_out_valid", {31'd0, ov9}, 32'd0);
    check("reset_is_corner", {31'd0, ic9}, 32'd0);
    run_cmp = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);

    // Directed cases, each spaced out and then back-to-back.
    drive(1'b0, 1'b1, 16'hFF80, 16'h0000); idle(3);
    drive(1'b0, 1'b1, 16'hAAAA, 16'h0000); idle(3);
    drive(1'b0, 1'b1, 16'h0000, 16'h0FFE); idle(3);
    drive(1'b0, 1'b1, 16'hF01F, 16'h0000); idle(3);
    drive(1'b0, 1'b1, 16'hF01E, 16'h0000); idle(3);
    drive(1'b0, 1'b1, 16'h000F, 16'h01F0); idle(3);
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF); idle(3);
    drive(1'b0, 1'b1, 16'hFF80, 16'h0000);
    drive(1'b0, 1'b1, 16'h000F, 16'h01F0);
    drive(1'b0, 1'b1, 16'hF01F, 16'h0000);
    idle(4);

    // Reset one cycle after a valid input: flushed, outputs cleared.
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(3);

    // Randomized stream with occasional resets.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), rand_mask(), rand_mask());
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    idle(5);
    check("queue_drained", cyc_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
